fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter and instruction-fetch sequencer for the rv32i core; the consumer side of branch_taken.
//  Issues one outstanding fetch at a time to instruction memory (valid/ready request, valid response).
//  Presents fetched words to decode. Redirects the PC on a taken branch or a jump, and flushes wrong-path fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000   address of the first fetch after reset
//  XLEN       32              address/data width; only 32 is supported
// PORTS
//  clk              in   1     clock; the single clock domain
//  rst              in   1     synchronous, active-high reset
//  branch_valid     in   1     BCU result valid this cycle (BCU output is registered, 1-cycle latency)
//  branch_taken     in   1     BCU decision; qualified by branch_valid
//  branch_target    in   32    branch destination address
//  jump_valid       in   1     unconditional redirect (JAL/JALR) this cycle
//  jump_target      in   32    jump destination address
//  stall            in   1     decode cannot accept the instruction this cycle
//  imem_req_valid   out  1     fetch request valid
//  imem_req_ready   in   1     memory accepts the request
//  imem_addr        out  32    fetch address; always equals pc while imem_req_valid=1
//  imem_rsp_valid   in   1     response data valid
//  imem_rsp_data    in   32    fetched instruction word
//  inst_valid       out  1     instruction valid toward decode
//  inst_data        out  32    instruction word
//  inst_pc          out  32    address of inst_data
//  misaligned_fault out  1     sticky; redirect target had target[1:0]!=0
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, all outputs 0 (inst_data 0, inst_pc 0, misaligned_fault 0).
//  FSM states: REQ, WAIT, DROP, HALT.
//  - REQ: imem_req_valid=1 unless (inst_valid && stall). Handshake (valid&&ready) moves to WAIT.
//  - WAIT: imem_rsp_valid registers the word into inst_data/inst_pc, sets inst_valid=1, sets pc=pc+4 (mod 2^32), returns to REQ.
//  - DROP: waits for the in-flight response, discards it, then returns to REQ.
//  - HALT: entered on a fault; no requests issued. Left only by rst.
//  Decode handshake:
//  - An instruction is consumed on a cycle with inst_valid && !stall.
//  - While stall=1, inst_valid, inst_data and inst_pc hold their values unchanged.
//  Redirect: redirect = (branch_valid && branch_taken) || jump_valid.
//  - If both branch and jump redirects occur in the same cycle, branch_target wins (the branch is the older instruction).
//  - The next cycle has pc=target and inst_valid=0 (flush), even when stall=1.
//  - State transition on redirect:
//    - REQ with handshake this cycle, or WAIT with no response this cycle -> DROP.
//    - WAIT with a response in the same cycle -> the response is discarded -> REQ.
//    - REQ with no handshake -> REQ, with the new pc.
//  - A redirect while in DROP updates pc and stays in DROP.
//  Fault: a redirect target with target[1:0]!=0 sets misaligned_fault=1, clears inst_valid, and enters HALT.
//  Response handling:
//  - imem_rsp_valid is ignored in REQ and HALT (e.g. a stale response after a mid-operation rst).
//  - imem_req_ready is ignored when imem_req_valid=0.
//  Latency: request-accept to inst_valid is at least 1 cycle after rsp_valid (response is registered).
//  A redirect reaches imem_addr on the next cycle.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//  - Adds outputs perf_fetch_cnt[31:0] (consumed instructions) and perf_redirect_cnt[31:0] (redirects taken).
//  - Both reset to 0 and wrap at 2^32.
//  FETCH_PERF_EN undefined: the counters and their ports are absent. All other behaviour is identical.
// STRUCTURE
//  Shared constants go in rv32i.vh: FSM state encodings FETCH_REQ/WAIT/DROP/HALT, and INST_NOP=32'h0000_0013 (debug fill).
//  One sub-module: fetch_outbuf.
//  - A 1-entry holding register (inst_valid/data/pc) with load, flush and stall-hold.
//  The FSM and pc live in fetch_unit.
// TESTING
//  1. Reset, ready=1, rsp 1 cycle later -> addrs 0x0,0x4,0x8; inst_pc tracks them; inst_data matches the memory model.
//  2. stall=1 for 3 cycles with inst_valid=1 -> outputs frozen; no new req; resumes at the next address on stall=0.
//  3. Branch taken to 0x100 while in WAIT; old rsp arrives 2 cycles later -> rsp dropped; next imem_addr=0x100; inst_valid=0 meanwhile.
//  4. branch_taken to 0x200 and jump_valid to 0x300 in the same cycle -> next fetch at 0x200.
//  5. jump_target=0x102 -> misaligned_fault=1; imem_req_valid stays 0 until rst; rst -> fetch restarts at RESET_PC.
//  6. rst mid-WAIT, stale rsp in the next cycle -> ignored; the first inst_valid comes from the fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the rv32i instruction-fetch slice.
// Imported by fetch_unit and fetch_outbuf.
package fetch_unit_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned INST_STEP  = 4;

    // Debug fill word (addi x0, x0, 0)
    localparam logic [FETCH_XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] data;
        logic [FETCH_XLEN-1:0] pc;
    } inst_pkt_t;

    function automatic logic is_misaligned(input logic [FETCH_XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_outbuf.sv
// One-entry holding register between the fetch FSM and decode.
// Flush beats load; a valid entry is kept until decode takes it (stall low).
module fetch_outbuf
    import fetch_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  logic      flush_i,
    input  logic      stall_i,
    input  inst_pkt_t pkt_i,
    output logic      valid_o,
    output inst_pkt_t pkt_o
);

    logic      valid_q, valid_d;
    inst_pkt_t pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end else if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/fetch_unit.sv
// PC and single-outstanding instruction-fetch sequencer with redirect/flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_valid,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misaligned_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic            req_valid_c;
    logic            handshake_c;
    logic            load_c;
    logic            flush_c;
    logic            consume_c;
    inst_pkt_t       rsp_pkt_c;
    inst_pkt_t       out_pkt;

    // The branch is older than a concurrent jump, so its target wins
    assign redirect_c  = (branch_valid && branch_taken) || jump_valid;
    assign target_c    = (branch_valid && branch_taken) ? branch_target : jump_target;
    assign req_valid_c = (state_q == FETCH_REQ) && !(inst_valid && stall);
    assign handshake_c = req_valid_c && imem_req_ready;
    assign consume_c   = inst_valid && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        load_c  = 1'b0;
        flush_c = 1'b0;
        if (state_q != FETCH_HALT && redirect_c) begin
            flush_c = 1'b1;
            if (is_misaligned(target_c)) begin
                fault_d = 1'b1;
                state_d = FETCH_HALT;
            end else begin
                pc_d = target_c;
                // Any fetch still in flight belongs to the wrong path
                case (state_q)
                    FETCH_REQ:  state_d = handshake_c    ? FETCH_DROP : FETCH_REQ;
                    FETCH_WAIT: state_d = imem_rsp_valid ? FETCH_REQ  : FETCH_DROP;
                    FETCH_DROP: state_d = imem_rsp_valid ? FETCH_REQ  : FETCH_DROP;
                    default:    state_d = state_q;
                endcase
            end
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (handshake_c) state_d = FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        load_c  = 1'b1;
                        pc_d    = pc_q + XLEN'(INST_STEP);
                        state_d = FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rsp_valid) state_d = FETCH_REQ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign rsp_pkt_c = '{data: imem_rsp_data, pc: pc_q};

    fetch_outbuf u_outbuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_c),
        .flush_i (flush_c),
        .stall_i (stall),
        .pkt_i   (rsp_pkt_c),
        .valid_o (inst_valid),
        .pkt_o   (out_pkt)
    );

    assign imem_req_valid   = req_valid_c;
    assign imem_addr        = pc_q;
    assign inst_data        = out_pkt.data;
    assign inst_pc          = out_pkt.pc;
    assign misaligned_fault = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (consume_c) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (state_q != FETCH_HALT && redirect_c) redir_cnt_d = redir_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign perf_fetch_cnt    = fetch_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;
`else
    logic unused_consume;
    assign unused_consume = consume_c;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch pipeline and a latency-randomized memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_valid, branch_taken, jump_valid, stall;
    logic [31:0] branch_target, jump_target;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        inst_valid, misaligned_fault;
    logic [31:0] inst_data, inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
`endif

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .branch_valid     (branch_valid),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump_valid       (jump_valid),
        .jump_target      (jump_target),
        .stall            (stall),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .misaligned_fault (misaligned_fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one fetch may be outstanding; a redirect marks it wrong-path
    logic [31:0] m_pc;
    logic        m_busy, m_discard, m_halt, m_fault;
    logic        m_iv;
    logic [31:0] m_id, m_ipc, m_fcnt, m_rcnt;
    logic        m_after_rst;

    // Memory: one pending request with a countdown until its response
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_dly;
    int          mem_lat;
    logic        mem_lat_rand;
    logic [31:0] addr_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_busy = 1'b0; m_discard = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        m_iv = 1'b0; m_id = 32'h0; m_ipc = 32'h0; m_fcnt = 32'h0; m_rcnt = 32'h0;
        m_after_rst = 1'b1;
    endtask

    task automatic step(input logic r, input logic bv, input logic bt, input logic [31:0] bta,
                        input logic jv, input logic [31:0] jta, input logic st, input logic rdy);
        logic        mreq, hs, rspv, redir, cons, rsp_use;
        logic [31:0] tgt, rdata;
        @(negedge clk);
        rspv  = mem_pend && (mem_dly == 0);
        rdata = rspv ? mem_word(mem_addr) : $urandom;
        rst = r; branch_valid = bv; branch_taken = bt; branch_target = bta;
        jump_valid = jv; jump_target = jta; stall = st; imem_req_ready = rdy;
        imem_rsp_valid = rspv; imem_rsp_data = rdata;
        mreq = !m_halt && !m_busy && !(m_iv && st);
        hs   = mreq && rdy;
        #1;
        chk("req_valid", 32'(imem_req_valid), 32'(mreq));
        if (mreq) chk("imem_addr", imem_addr, m_pc);
        if (hs) addr_log.push_back(imem_addr);
        @(posedge clk);
        if (rspv) mem_pend = 1'b0;
        else if (mem_pend) mem_dly--;
        if (hs) begin
            mem_pend = 1'b1;
            mem_addr = m_pc;
            mem_dly  = mem_lat_rand ? int'($urandom_range(0, 2)) : mem_lat;
        end
        if (r) begin
            model_reset();
        end else begin
            m_after_rst = 1'b0;
            redir   = (bv && bt) || jv;
            tgt     = (bv && bt) ? bta : jta;
            cons    = m_iv && !st;
            rsp_use = m_busy && rspv;
            if (!m_halt) begin
                if (cons) m_fcnt++;
                if (redir) begin
                    m_rcnt++;
                    m_iv = 1'b0;
                    if (tgt[1:0] != 2'b00) begin
                        m_fault = 1'b1; m_halt = 1'b1; m_busy = 1'b0;
                    end else begin
                        m_pc = tgt;
                        if (hs) begin
                            m_busy = 1'b1; m_discard = 1'b1;
                        end else if (rsp_use) begin
                            m_busy = 1'b0; m_discard = 1'b0;
                        end else if (m_busy) begin
                            m_discard = 1'b1;
                        end
                    end
                end else begin
                    if (cons) m_iv = 1'b0;
                    if (hs) begin
                        m_busy = 1'b1; m_discard = 1'b0;
                    end else if (rsp_use) begin
                        if (!m_discard) begin
                            m_iv = 1'b1; m_id = rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                        end
                        m_busy = 1'b0; m_discard = 1'b0;
                    end
                end
            end
        end
        #1;
        chk("inst_valid", 32'(inst_valid), 32'(m_iv));
        chk("misaligned_fault", 32'(misaligned_fault), 32'(m_fault));
        if (m_iv || m_after_rst) begin
            chk("inst_data", inst_data, m_id);
            chk("inst_pc", inst_pc, m_ipc);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
        chk("perf_redirect_cnt", perf_redirect_cnt, m_rcnt);
`endif
    endtask

    task automatic idle(input int n, input logic st, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, st, rdy);
    endtask

    task automatic do_reset(input logic rdy);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    initial begin
        logic [31:0] bta, jta;
        logic        bv, jv, st, rdy;
        rst = 1'b1; branch_valid = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump_valid = 1'b0; jump_target = '0; stall = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mem_pend = 1'b0; mem_addr = '0; mem_dly = 0; mem_lat = 0; mem_lat_rand = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // 1: sequential fetch 0x0, 0x4, 0x8 with single-cycle memory
        do_reset(1'b0);
        addr_log.delete();
        idle(7, 1'b0, 1'b1);
        chk("t1_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("t1_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD_BEEF, 32'h4);
        chk("t1_addr2", addr_log.size() > 2 ? addr_log[2] : 32'hDEAD_BEEF, 32'h8);

        // 2: decode stall freezes the buffer and blocks new requests
        do_reset(1'b0);
        idle(2, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b1);
        addr_log.delete();
        idle(3, 1'b0, 1'b1);
        chk("t2_resume", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD_BEEF, 32'h4);

        // 3: branch while waiting; late response is dropped
        do_reset(1'b0);
        mem_lat = 2;
        addr_log.delete();
        idle(1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(5, 1'b0, 1'b1);
        chk("t3_target", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD_BEEF, 32'h100);

        // 4: simultaneous branch and jump, branch wins
        do_reset(1'b0);
        mem_lat = 0;
        addr_log.delete();
        idle(1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b1);
        idle(3, 1'b0, 1'b1);
        chk("t4_target", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD_BEEF, 32'h200);

        // 5: misaligned jump halts until reset
        do_reset(1'b0);
        idle(2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b1);
        idle(5, 1'b0, 1'b1);
        chk("t5_fault", 32'(misaligned_fault), 32'h1);
        do_reset(1'b0);
        addr_log.delete();
        idle(3, 1'b0, 1'b1);
        chk("t5_restart", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD_BEEF, 32'h0);

        // 6: reset mid-WAIT, stale response after reset is ignored
        do_reset(1'b0);
        idle(2, 1'b0, 1'b1);
        mem_lat = 1;
        idle(1, 1'b0, 1'b1);
        do_reset(1'b0);
        idle(1, 1'b0, 1'b0);
        mem_lat = 0;
        idle(2, 1'b0, 1'b1);
        chk("t6_valid", 32'(inst_valid), 32'h1);
        chk("t6_pc", inst_pc, 32'h0);

        // Randomized traffic
        mem_lat_rand = 1'b1;
        for (int ep = 0; ep < 15; ep++) begin
            do_reset(1'($urandom_range(0, 1)));
            for (int c = 0; c < 120; c++) begin
                bv  = ($urandom_range(0, 7) == 0);
                jv  = ($urandom_range(0, 15) == 0);
                bta = $urandom;
                jta = $urandom;
                if ($urandom_range(0, 40) != 0) bta[1:0] = 2'b00;
                if ($urandom_range(0, 40) != 0) jta[1:0] = 2'b00;
                st  = ($urandom_range(0, 9) < 3);
                rdy = ($urandom_range(0, 9) < 7);
                step(1'b0, bv, 1'($urandom_range(0, 1)), bta, jv, jta, st, rdy);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
